// File: rtl/sdram_port_arbiter.sv
// Two-master round-robin arbiter for the SDRAM controller's Avalon-MM slave port.
// Commands pass combinationally through grant muxes; read responses are routed in order via a 1-bit ID FIFO.
module sdram_port_arbiter #(
    parameter int ADDR_W      = 25,
    parameter int DATA_W      = 16,
    parameter int MAX_PENDING = 4
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata,
    input  logic                s_readdatavalid,

    output logic                err_unexpected
);

    localparam int PTR_W = $clog2(MAX_PENDING);
    localparam int CNT_W = $clog2(MAX_PENDING + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_PENDING);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   last, last_nxt;

    logic req0, req1;
    logic full, empty;
    logic cmd_done;
    logic push, pop, push_id, head;

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_mem [MAX_PENDING];

    assign req0  = m0_read | m0_write;
    assign req1  = m1_read | m1_write;
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // Grant-select muxes; a read from the granted master is held off while the ID FIFO is full.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latches).
        s_address      = '0;
        s_writedata    = '0;
        s_byteenable   = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        case (state)
            GRANT0: begin
                s_address      = m0_address;
                s_writedata    = m0_writedata;
                s_byteenable   = m0_byteenable;
                s_read         = m0_read & ~full;
                s_write        = m0_write;
                m0_waitrequest = s_waitrequest | (m0_read & full);
            end
            GRANT1: begin
                s_address      = m1_address;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                s_read         = m1_read & ~full;
                s_write        = m1_write;
                m1_waitrequest = s_waitrequest | (m1_read & full);
            end
            default: ;
        endcase
    end

    assign cmd_done = (s_read | s_write) & ~s_waitrequest;

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (req0 && (!req1 || last)) begin
                    state_nxt = GRANT0;
                end else if (req1) begin
                    state_nxt = GRANT1;
                end
            end
            GRANT0: begin
                if (cmd_done) begin
                    last_nxt = 1'b0;
                    if (req1)      state_nxt = GRANT1;
                    else if (req0) state_nxt = GRANT0;
                    else           state_nxt = IDLE;
                end else if (!req0) begin
                    state_nxt = IDLE;
                end
            end
            GRANT1: begin
                if (cmd_done) begin
                    last_nxt = 1'b1;
                    if (req0)      state_nxt = GRANT0;
                    else if (req1) state_nxt = GRANT1;
                    else           state_nxt = IDLE;
                end else if (!req1) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    // Read-ID FIFO: remembers which master owns each outstanding read, oldest at the head.
    assign push    = cmd_done & s_read;
    assign push_id = (state == GRANT1);
    assign pop     = s_readdatavalid & ~empty;
    assign head    = fifo_mem[rd_ptr];

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            err_unexpected <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
            if (s_readdatavalid && empty) err_unexpected <= 1'b1;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; pointers and count alone decide which entries are valid.
    always_ff @(posedge clk_clk) begin
        if (push) fifo_mem[wr_ptr] <= push_id;
    end

    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = s_readdatavalid & ~empty & ~head;
    assign m1_readdatavalid = s_readdatavalid & ~empty &  head;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: a cycle table for the single-read / unexpected-response case,
// then hand-written sequences for arbitration, stalls, FIFO throttling and asynchronous reset.
module tb_sdram_port_arbiter;

    localparam int ADDR_W      = 25;
    localparam int DATA_W      = 16;
    localparam int MAX_PENDING = 4;

    localparam logic [ADDR_W-1:0] A0 = 25'h0000123;
    localparam logic [ADDR_W-1:0] A1 = 25'h0000456;

    logic              clk_clk = 1'b0;
    logic              reset_reset_n = 1'b0;
    logic [ADDR_W-1:0] m0_address, m1_address;
    logic              m0_read, m0_write, m1_read, m1_write;
    logic [DATA_W-1:0] m0_writedata, m1_writedata;
    logic [1:0]        m0_byteenable, m1_byteenable;
    logic              m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0] m0_readdata, m1_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic [ADDR_W-1:0] s_address;
    logic              s_read, s_write;
    logic [DATA_W-1:0] s_writedata;
    logic [1:0]        s_byteenable;
    logic              s_waitrequest;
    logic [DATA_W-1:0] s_readdata;
    logic              s_readdatavalid;
    logic              err_unexpected;

    int n_checks = 0;
    int n_fail   = 0;

    sdram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PENDING(MAX_PENDING)
    ) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid),
        .err_unexpected(err_unexpected)
    );

    always #5 clk_clk = ~clk_clk;

    // One table row = inputs for one cycle and the outputs expected in that cycle.
    typedef struct {
        string             name;
        logic [3:0]        cmd;      // {m0_read, m0_write, m1_read, m1_write}
        logic              s_wait;
        logic              s_rdv;
        logic [DATA_W-1:0] s_rdata;
        logic [1:0]        e_srw;    // {s_read, s_write}
        logic [1:0]        e_wait;   // {m0_waitrequest, m1_waitrequest}
        logic [1:0]        e_rdv;    // {m0_readdatavalid, m1_readdatavalid}
        logic              e_err;
        logic              chk_addr;
        logic [ADDR_W-1:0] e_addr;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    function automatic vec_t mk(input string n, input logic [3:0] cmd, input logic sw, input logic rdv,
                                input logic [DATA_W-1:0] rd, input logic [1:0] srw, input logic [1:0] wt,
                                input logic [1:0] erdv, input logic err, input logic ca,
                                input logic [ADDR_W-1:0] addr);
        vec_t v;
        v.name = n; v.cmd = cmd; v.s_wait = sw; v.s_rdv = rdv; v.s_rdata = rd;
        v.e_srw = srw; v.e_wait = wt; v.e_rdv = erdv; v.e_err = err; v.chk_addr = ca; v.e_addr = addr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
        s_waitrequest = 1'b0; s_readdatavalid = 1'b0; s_readdata = '0;
        m0_address = A0; m1_address = A1;
        m0_writedata = 16'h0A0A; m1_writedata = 16'h0B0B;
        m0_byteenable = 2'b11; m1_byteenable = 2'b11;
    endtask

    task automatic do_reset();
        drive_idle();
        reset_reset_n = 1'b0;
        repeat (2) @(posedge clk_clk);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] rsp_data [5];
        logic [1:0]        rsp_route [5];
        int i0, i1, idx;

        vecs[0] = mk("rd_req",   4'b1000, 1'b0, 1'b0, 16'h0000, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0, '0);
        vecs[1] = mk("rd_cmd",   4'b1000, 1'b0, 1'b0, 16'h0000, 2'b10, 2'b01, 2'b00, 1'b0, 1'b1, A0);
        vecs[2] = mk("rd_resp",  4'b0000, 1'b0, 1'b1, 16'hBEEF, 2'b00, 2'b01, 2'b10, 1'b0, 1'b1, A0);
        vecs[3] = mk("idle",     4'b0000, 1'b0, 1'b0, 16'h0000, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0, '0);
        vecs[4] = mk("unexp",    4'b0000, 1'b0, 1'b1, 16'h1234, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0, '0);
        vecs[5] = mk("err_set",  4'b0000, 1'b0, 1'b0, 16'h0000, 2'b00, 2'b11, 2'b00, 1'b1, 1'b0, '0);
        vecs[6] = mk("err_req",  4'b0001, 1'b0, 1'b0, 16'h0000, 2'b00, 2'b11, 2'b00, 1'b1, 1'b0, '0);
        vecs[7] = mk("err_wr",   4'b0001, 1'b0, 1'b0, 16'h0000, 2'b01, 2'b10, 2'b00, 1'b1, 1'b1, A1);

        // Reset state
        drive_idle();
        #2;
        check("rst_srw",  {s_read, s_write}, 2'b00);
        check("rst_wait", {m0_waitrequest, m1_waitrequest}, 2'b11);
        check("rst_err",  err_unexpected, 1'b0);
        do_reset();

        // Single read by m0, then an unexpected response
        for (int i = 0; i < NV; i++) begin
            tick();
            {m0_read, m0_write, m1_read, m1_write} = vecs[i].cmd;
            s_waitrequest   = vecs[i].s_wait;
            s_readdatavalid = vecs[i].s_rdv;
            s_readdata      = vecs[i].s_rdata;
            @(negedge clk_clk);
            check({vecs[i].name, "/srw"},  {s_read, s_write}, vecs[i].e_srw);
            check({vecs[i].name, "/wait"}, {m0_waitrequest, m1_waitrequest}, vecs[i].e_wait);
            check({vecs[i].name, "/rdv"},  {m0_readdatavalid, m1_readdatavalid}, vecs[i].e_rdv);
            check({vecs[i].name, "/err"},  err_unexpected, vecs[i].e_err);
            if (vecs[i].chk_addr) check({vecs[i].name, "/addr"}, s_address, vecs[i].e_addr);
            if (vecs[i].s_rdv) begin
                check({vecs[i].name, "/m0_data"}, m0_readdata, vecs[i].s_rdata);
                check({vecs[i].name, "/m1_data"}, m1_readdata, vecs[i].s_rdata);
            end
        end

        // Both masters write continuously: strict alternation, nothing lost
        do_reset();
        i0 = 0; i1 = 0;
        for (int k = 0; k <= 16; k++) begin
            tick();
            m0_write = (i0 < 8); m0_address = 25'h100 + 25'(i0); m0_writedata = 16'hA000 + 16'(i0);
            m1_write = (i1 < 8); m1_address = 25'h200 + 25'(i1); m1_writedata = 16'hB000 + 16'(i1);
            @(negedge clk_clk);
            if (k == 0) begin
                check("wr_idle_wait", {m0_waitrequest, m1_waitrequest}, 2'b11);
            end else begin
                idx = (k - 1) / 2;
                check("wr_s_write", s_write, 1'b1);
                if (k % 2 == 1) begin
                    check("wr_wait_m0turn", {m0_waitrequest, m1_waitrequest}, 2'b01);
                    check("wr_addr_m0", s_address, 25'h100 + 25'(idx));
                    check("wr_data_m0", s_writedata, 16'hA000 + 16'(idx));
                end else begin
                    check("wr_wait_m1turn", {m0_waitrequest, m1_waitrequest}, 2'b10);
                    check("wr_addr_m1", s_address, 25'h200 + 25'(idx));
                    check("wr_data_m1", s_writedata, 16'hB000 + 16'(idx));
                end
            end
            if (m0_write && !m0_waitrequest) i0++;
            if (m1_write && !m1_waitrequest) i1++;
        end
        check("wr_count_m0", i0, 8);
        check("wr_count_m1", i1, 8);

        // m1 write stalled by the slave for 5 cycles while m0 waits
        do_reset();
        tick();
        m1_write = 1'b1; s_waitrequest = 1'b1;
        @(negedge clk_clk);
        check("stall_idle_wait", {m0_waitrequest, m1_waitrequest}, 2'b11);
        for (int k = 1; k <= 5; k++) begin
            tick();
            m0_write = 1'b1;
            @(negedge clk_clk);
            check("stall_hold_addr", s_address, A1);
            check("stall_hold_wait", {m0_waitrequest, m1_waitrequest}, 2'b11);
        end
        tick();
        s_waitrequest = 1'b0;
        @(negedge clk_clk);
        check("stall_done_addr", s_address, A1);
        check("stall_done_wait", {m0_waitrequest, m1_waitrequest}, 2'b10);
        tick();
        m1_write = 1'b0;
        @(negedge clk_clk);
        check("stall_next_addr", s_address, A0);
        check("stall_next_wait", {m0_waitrequest, m1_waitrequest}, 2'b01);

        // Four reads fill the ID FIFO; a fifth is throttled until after the first pop
        do_reset();
        for (int k = 0; k <= 4; k++) begin
            tick();
            m0_read = 1'b1; m1_read = 1'b1;
            @(negedge clk_clk);
            if (k > 0) begin
                check("fill_s_read", s_read, 1'b1);
                check("fill_addr", s_address, (k % 2 == 1) ? A0 : A1);
            end
        end
        tick();
        m1_read = 1'b0;
        @(negedge clk_clk);
        check("thr_s_read", s_read, 1'b0);
        check("thr_wait", {m0_waitrequest, m1_waitrequest}, 2'b11);
        tick();
        s_readdatavalid = 1'b1; s_readdata = 16'h1111;
        @(negedge clk_clk);
        check("thr_pop_s_read", s_read, 1'b0);
        check("thr_pop_rdv", {m0_readdatavalid, m1_readdatavalid}, 2'b10);
        tick();
        s_readdatavalid = 1'b0;
        @(negedge clk_clk);
        check("thr_release_s_read", s_read, 1'b1);
        check("thr_release_wait", m0_waitrequest, 1'b0);
        rsp_data  = '{16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h0000};
        rsp_route = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
        for (int r = 0; r < 5; r++) begin
            tick();
            m0_read = 1'b0;
            s_readdatavalid = (r < 4);
            s_readdata = rsp_data[r];
            @(negedge clk_clk);
            check("route_rdv", {m0_readdatavalid, m1_readdatavalid}, rsp_route[r]);
        end
        check("route_no_err", err_unexpected, 1'b0);

        // Asynchronous reset mid-transfer with two reads pending
        do_reset();
        tick(); m0_read = 1'b1;
        tick(); m1_read = 1'b1;
        tick();
        tick(); m1_read = 1'b0; s_waitrequest = 1'b1;
        @(negedge clk_clk);
        check("ar_pre_s_read", s_read, 1'b1);
        #1;
        reset_reset_n = 1'b0;
        s_readdatavalid = 1'b1;
        #1;
        check("ar_srw",  {s_read, s_write}, 2'b00);
        check("ar_wait", {m0_waitrequest, m1_waitrequest}, 2'b11);
        check("ar_rdv",  {m0_readdatavalid, m1_readdatavalid}, 2'b00);
        check("ar_err",  err_unexpected, 1'b0);
        drive_idle();
        repeat (2) @(posedge clk_clk);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        tick();
        m0_write = 1'b1; m1_write = 1'b1;
        @(negedge clk_clk);
        check("ar_idle_wait", {m0_waitrequest, m1_waitrequest}, 2'b11);
        tick();
        @(negedge clk_clk);
        check("ar_tie_wait", {m0_waitrequest, m1_waitrequest}, 2'b01);
        check("ar_tie_addr", s_address, A0);
        tick();
        m0_write = 1'b0; m1_write = 1'b0;
        s_readdatavalid = 1'b1;
        @(negedge clk_clk);
        check("ar_stale_rdv", {m0_readdatavalid, m1_readdatavalid}, 2'b00);
        tick();
        s_readdatavalid = 1'b0;
        @(negedge clk_clk);
        check("ar_stale_err", err_unexpected, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
